// File: rtl/y86_pkg.sv
// y86_pkg
// Definitions shared by the Y86-64 pipeline stages: instruction codes, status
// codes, the "no register" id, the W pipeline-register layout and small
// icode-decode helpers used by the memory stage.
package y86_pkg;

  localparam int WORD_W = 64;

  // Instruction codes.
  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_e;

  // Pipeline status codes.
  typedef enum logic [3:0] {
    SAOK = 4'h1,
    SHLT = 4'h2,
    SADR = 4'h3,
    SINS = 4'h4
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;

  // Contents of the W pipeline register.
  typedef struct packed {
    logic [3:0]        stat;
    logic [3:0]        icode;
    logic [WORD_W-1:0] valE;
    logic [WORD_W-1:0] valM;
    logic [3:0]        dstE;
    logic [3:0]        dstM;
  } w_reg_t;

  // Instructions that read an 8-byte word from data memory.
  function automatic logic mem_reads(input logic [3:0] icode);
    return (icode == IMRMOVQ) || (icode == IPOPQ) || (icode == IRET);
  endfunction

  // Instructions that write M_valA to data memory.
  function automatic logic mem_writes(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == ICALL) || (icode == IPUSHQ);
  endfunction

  // Stack pops take their address from valA (old %rsp); everything else
  // that touches memory uses the ALU result valE.
  function automatic logic addr_from_vala(input logic [3:0] icode);
    return (icode == IRET) || (icode == IPOPQ);
  endfunction

  function automatic logic addr_from_vale(input logic [3:0] icode);
    return (icode == IRMMOVQ) || (icode == IMRMOVQ) ||
           (icode == ICALL)   || (icode == IPUSHQ);
  endfunction

endpackage

// File: rtl/pipe_dmem.sv
// pipe_dmem
// Byte-addressed data memory for the Y86-64 memory stage.
//  - 8-byte little-endian combinational read at any byte alignment.
//  - Clocked 8-byte pipeline write, gated by the caller's permission.
//  - Loader write port; out-of-range loader bytes are dropped, and a loader
//    write in the same cycle discards the pipeline write entirely.
//  - Range check: an access faults when addr > MEM_BYTES-8 (unsigned).
// The byte array has no reset so its contents survive a pipeline reset.
//
// Ports:
//   clk_i       clock
//   rst_ni      active-low reset (only suppresses the pipeline write)
//   rd_i        pipeline read request
//   wr_i        pipeline write request
//   wr_allow_i  pipeline write permitted by stage status
//   addr_i      pipeline byte address
//   wdata_i     pipeline write data
//   ld_we_i     loader write enable
//   ld_addr_i   loader byte address
//   ld_data_i   loader write data
//   err_o       pipeline access out of range
//   rdata_o     read data (0 when no read or on error)
module pipe_dmem
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              rd_i,
  input  logic              wr_i,
  input  logic              wr_allow_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [ADDR_W-1:0] wdata_i,
  input  logic              ld_we_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [ADDR_W-1:0] ld_data_i,
  output logic              err_o,
  output logic [ADDR_W-1:0] rdata_o
);

  localparam int AW = $clog2(MEM_BYTES);
  localparam int NB = ADDR_W / 8;
  // Highest address at which a full word still fits in the array.
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(MEM_BYTES - NB);

  logic [7:0] mem_q [MEM_BYTES];
  logic       wr_commit;

  // Full-width unsigned compare so large addresses never wrap into range.
  assign err_o = (rd_i || wr_i) && (addr_i > LAST_WORD);

  // A pending pipeline write is dropped while reset is asserted, when the
  // stage status forbids it, when it faults, or when the loader is writing.
  assign wr_commit = wr_i && !err_o && wr_allow_i && !ld_we_i && rst_ni;

  always_comb begin
    rdata_o = '0;
    if (rd_i && !err_o) begin
      for (int i = 0; i < NB; i++) begin
        rdata_o[8*i +: 8] = mem_q[addr_i[AW-1:0] + AW'(i)];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (ld_we_i) begin
      for (int i = 0; i < NB; i++) begin
        // Byte i lands at ld_addr+i; compare without forming the sum so a
        // huge ld_addr cannot wrap around into the array.
        if (ld_addr_i <= ADDR_W'(MEM_BYTES - 1 - i)) begin
          mem_q[ld_addr_i[AW-1:0] + AW'(i)] <= ld_data_i[8*i +: 8];
        end
      end
    end else if (wr_commit) begin
      for (int i = 0; i < NB; i++) begin
        mem_q[addr_i[AW-1:0] + AW'(i)] <= wdata_i[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/pipe_memory.sv
// pipe_memory
// Y86-64 pipeline memory stage. Takes the M pipeline register, performs the
// data-memory read or write, produces m_stat / m_valM combinationally for
// forwarding and pipeline control, and owns the W pipeline register.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   M_stat .. M_dstM           M pipeline register contents
//   W_stall                    hold the W register this cycle
//   ld_we, ld_addr, ld_data    loader write port into data memory
//   m_stat, m_valM             combinational stage status / read data
//   W_stat .. W_dstM           W pipeline register outputs
module pipe_memory
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int ADDR_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [3:0]        M_stat,
  input  logic [3:0]        M_icode,
  input  logic              M_Cnd,
  input  logic [ADDR_W-1:0] M_valE,
  input  logic [ADDR_W-1:0] M_valA,
  input  logic [3:0]        M_dstE,
  input  logic [3:0]        M_dstM,
  input  logic              W_stall,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [ADDR_W-1:0] ld_data,
  output logic [3:0]        m_stat,
  output logic [ADDR_W-1:0] m_valM,
  output logic [3:0]        W_stat,
  output logic [3:0]        W_icode,
  output logic [ADDR_W-1:0] W_valE,
  output logic [ADDR_W-1:0] W_valM,
  output logic [3:0]        W_dstE,
  output logic [3:0]        W_dstM
);

  logic              mem_rd;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic              dmem_error;
  logic [ADDR_W-1:0] rdata;
  logic              wr_allow;
  w_reg_t            w_q;
  w_reg_t            w_d;

  // The branch outcome has already been consumed by fetch; it is not
  // carried into W.
  logic unused_cnd;
  assign unused_cnd = M_Cnd;

  // Access decode.
  always_comb begin
    mem_rd   = mem_reads(M_icode);
    mem_wr   = mem_writes(M_icode);
    mem_addr = '0;
    if (addr_from_vale(M_icode)) begin
      mem_addr = M_valE;
    end else if (addr_from_vala(M_icode)) begin
      mem_addr = M_valA;
    end
  end

  // Stores only commit while both this stage and writeback are healthy;
  // once W has latched a halt or fault, later stores are squashed.
  assign wr_allow = (W_stat == SAOK) && (m_stat == SAOK);

  pipe_dmem #(
    .MEM_BYTES (MEM_BYTES),
    .ADDR_W    (ADDR_W)
  ) u_dmem (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .rd_i       (mem_rd),
    .wr_i       (mem_wr),
    .wr_allow_i (wr_allow),
    .addr_i     (mem_addr),
    .wdata_i    (M_valA),
    .ld_we_i    (ld_we),
    .ld_addr_i  (ld_addr),
    .ld_data_i  (ld_data),
    .err_o      (dmem_error),
    .rdata_o    (rdata)
  );

  assign m_stat = dmem_error ? SADR : M_stat;
  assign m_valM = rdata;

  // W register next state: load unless stalled or frozen by a non-AOK status.
  always_comb begin
    w_d = w_q;
    if (!W_stall && (w_q.stat == SAOK)) begin
      w_d.stat  = m_stat;
      w_d.icode = M_icode;
      w_d.valE  = M_valE;
      w_d.valM  = m_valM;
      w_d.dstE  = M_dstE;
      w_d.dstM  = M_dstM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_q.stat  <= SAOK;
      w_q.icode <= INOP;
      w_q.valE  <= '0;
      w_q.valM  <= '0;
      w_q.dstE  <= RNONE;
      w_q.dstM  <= RNONE;
    end else begin
      w_q <= w_d;
    end
  end

  assign W_stat  = w_q.stat;
  assign W_icode = w_q.icode;
  assign W_valE  = w_q.valE;
  assign W_valM  = w_q.valM;
  assign W_dstE  = w_q.dstE;
  assign W_dstM  = w_q.dstM;

endmodule

// File: tb/tb_pipe_memory.sv
module tb_pipe_memory;
  import y86_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
  logic        M_Cnd;
  logic [63:0] M_valE, M_valA;
  logic        W_stall, ld_we;
  logic [63:0] ld_addr, ld_data;
  logic [3:0]  m_stat, W_stat, W_icode, W_dstE, W_dstM;
  logic [63:0] m_valM, W_valE, W_valM;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          chk;
    string       name;
    logic [3:0]  stat;
    logic [63:0] valM;
  } m_exp_t;

  typedef struct {
    bit          chk;
    string       name;
    logic [3:0]  stat;
    logic [3:0]  icode;
    logic [63:0] valE;
    logic [63:0] valM;
    logic [3:0]  dstE;
    logic [3:0]  dstM;
  } w_exp_t;

  m_exp_t mq[$];
  w_exp_t wq[$];

  pipe_memory #(.MEM_BYTES(1024), .ADDR_W(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .M_stat(M_stat), .M_icode(M_icode), .M_Cnd(M_Cnd),
    .M_valE(M_valE), .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM),
    .W_stall(W_stall), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
    .m_stat(m_stat), .m_valM(m_valM),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM)
  );

  always #5 clk = ~clk;

  task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic m_exp_t mx(input string n, input logic [3:0] s, input logic [63:0] v);
    m_exp_t e;
    e.chk = 1'b1; e.name = n; e.stat = s; e.valM = v;
    return e;
  endfunction

  function automatic m_exp_t mnone();
    m_exp_t e;
    e.chk = 1'b0; e.name = "none"; e.stat = 4'h0; e.valM = 64'h0;
    return e;
  endfunction

  function automatic w_exp_t wx(input string n, input logic [3:0] s, input logic [3:0] ic,
                                input logic [63:0] ve, input logic [63:0] vm,
                                input logic [3:0] de, input logic [3:0] dm);
    w_exp_t e;
    e.chk = 1'b1; e.name = n; e.stat = s; e.icode = ic;
    e.valE = ve; e.valM = vm; e.dstE = de; e.dstM = dm;
    return e;
  endfunction

  function automatic w_exp_t wnone();
    w_exp_t e;
    e.chk = 1'b0; e.name = "none"; e.stat = 4'h0; e.icode = 4'h0;
    e.valE = 64'h0; e.valM = 64'h0; e.dstE = 4'h0; e.dstM = 4'h0;
    return e;
  endfunction

  task automatic setm(input logic [3:0] st, input logic [3:0] ic, input logic [63:0] ve,
                      input logic [63:0] va, input logic [3:0] de, input logic [3:0] dm);
    M_stat = st; M_icode = ic; M_valE = ve; M_valA = va; M_dstE = de; M_dstM = dm;
    M_Cnd = 1'b0; W_stall = 1'b0; ld_we = 1'b0; ld_addr = 64'h0; ld_data = 64'h0;
  endtask

  task automatic load(input logic [63:0] a, input logic [63:0] d);
    ld_we = 1'b1; ld_addr = a; ld_data = d;
  endtask

  // Issue the currently driven vector: record its expectations, then move
  // on to the next falling edge.
  task automatic tick(input m_exp_t me, input w_exp_t we);
    mq.push_back(me);
    wq.push_back(we);
    @(negedge clk);
  endtask

  task automatic check_w_reset(input string tag);
    check64({tag, "_W_stat"},  {60'h0, W_stat},  {60'h0, SAOK});
    check64({tag, "_W_icode"}, {60'h0, W_icode}, {60'h0, INOP});
    check64({tag, "_W_valE"},  W_valE, 64'h0);
    check64({tag, "_W_valM"},  W_valM, 64'h0);
    check64({tag, "_W_dstE"},  {60'h0, W_dstE},  {60'h0, RNONE});
    check64({tag, "_W_dstM"},  {60'h0, W_dstM},  {60'h0, RNONE});
  endtask

  // Combinational outputs: sampled mid low phase of the cycle they belong to.
  initial begin
    m_exp_t me;
    forever begin
      @(negedge clk);
      #2;
      if (mq.size() > 0) begin
        me = mq.pop_front();
        if (me.chk) begin
          check64({me.name, "_m_stat"}, {60'h0, m_stat}, {60'h0, me.stat});
          check64({me.name, "_m_valM"}, m_valM, me.valM);
        end
      end
    end
  end

  // W register: sampled just after the edge that loads it.
  initial begin
    w_exp_t we;
    forever begin
      @(posedge clk);
      #1;
      if (wq.size() > 0) begin
        we = wq.pop_front();
        if (we.chk) begin
          check64({we.name, "_W_stat"},  {60'h0, W_stat},  {60'h0, we.stat});
          check64({we.name, "_W_icode"}, {60'h0, W_icode}, {60'h0, we.icode});
          check64({we.name, "_W_valE"},  W_valE, we.valE);
          check64({we.name, "_W_valM"},  W_valM, we.valM);
          check64({we.name, "_W_dstE"},  {60'h0, W_dstE},  {60'h0, we.dstE});
          check64({we.name, "_W_dstM"},  {60'h0, W_dstM},  {60'h0, we.dstM});
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    setm(SAOK, INOP, 64'h0, 64'h0, RNONE, RNONE);
    repeat (2) @(negedge clk);
    #1;
    check_w_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Store then load back.
    setm(SAOK, IRMMOVQ, 64'h40, 64'h1122334455667788, RNONE, RNONE);
    tick(mx("st40", SAOK, 64'h0), wx("st40", SAOK, IRMMOVQ, 64'h40, 64'h0, RNONE, RNONE));
    setm(SAOK, IMRMOVQ, 64'h40, 64'h0, RNONE, 4'h3);
    tick(mx("ld40", SAOK, 64'h1122334455667788),
         wx("ld40", SAOK, IMRMOVQ, 64'h40, 64'h1122334455667788, RNONE, 4'h3));

    // Little-endian unaligned read across loader-written words.
    setm(SAOK, INOP, 64'h0, 64'h0, RNONE, RNONE);
    load(64'h10, 64'h0807060504030201);
    tick(mx("nop", SAOK, 64'h0), wx("nop", SAOK, INOP, 64'h0, 64'h0, RNONE, RNONE));
    setm(SAOK, INOP, 64'h0, 64'h0, RNONE, RNONE);
    load(64'h18, 64'hAA);
    tick(mnone(), wnone());
    setm(SAOK, IMRMOVQ, 64'h11, 64'h0, RNONE, 4'h2);
    tick(mx("unal", SAOK, 64'hAA08070605040302),
         wx("unal", SAOK, IMRMOVQ, 64'h11, 64'hAA08070605040302, RNONE, 4'h2));

    // Pop reads at valA, W keeps valE.
    setm(SAOK, INOP, 64'h0, 64'h0, RNONE, RNONE);
    load(64'h80, 64'h5);
    tick(mnone(), wnone());
    setm(SAOK, IPOPQ, 64'h88, 64'h80, 4'h4, 4'h6);
    tick(mx("pop", SAOK, 64'h5), wx("pop", SAOK, IPOPQ, 64'h88, 64'h5, 4'h4, 4'h6));

    // Loader and pipeline write collide: loader wins.
    setm(SAOK, IRMMOVQ, 64'h20, 64'hBBBB, RNONE, RNONE);
    load(64'h20, 64'hAAAA);
    tick(mx("coll", SAOK, 64'h0), wx("coll", SAOK, IRMMOVQ, 64'h20, 64'h0, RNONE, RNONE));
    setm(SAOK, IMRMOVQ, 64'h20, 64'h0, RNONE, 4'h1);
    tick(mx("coll_rd", SAOK, 64'hAAAA), wx("coll_rd", SAOK, IMRMOVQ, 64'h20, 64'hAAAA, RNONE, 4'h1));

    // Read in the same cycle as a write sees old data; next cycle sees new.
    setm(SAOK, IRMMOVQ, 64'h100, 64'h1111, RNONE, RNONE);
    tick(mx("st100", SAOK, 64'h0), wnone());
    setm(SAOK, IMRMOVQ, 64'h100, 64'h0, RNONE, 4'h2);
    load(64'h100, 64'h7777);
    tick(mx("same_cyc", SAOK, 64'h1111), wx("same_cyc", SAOK, IMRMOVQ, 64'h100, 64'h1111, RNONE, 4'h2));
    setm(SAOK, IMRMOVQ, 64'h100, 64'h0, RNONE, 4'h2);
    tick(mx("next_cyc", SAOK, 64'h7777), wx("next_cyc", SAOK, IMRMOVQ, 64'h100, 64'h7777, RNONE, 4'h2));

    // Call pushes, ret pops.
    setm(SAOK, ICALL, 64'h200, 64'h1234, 4'h4, RNONE);
    tick(mx("call", SAOK, 64'h0), wx("call", SAOK, ICALL, 64'h200, 64'h0, 4'h4, RNONE));
    setm(SAOK, IRET, 64'h208, 64'h200, 4'h4, RNONE);
    tick(mx("ret", SAOK, 64'h1234), wx("ret", SAOK, IRET, 64'h208, 64'h1234, 4'h4, RNONE));

    // Stall holds W for two cycles, then it loads.
    setm(SAOK, IOPQ, 64'd30, 64'h0, 4'h2, RNONE);
    W_stall = 1'b1;
    tick(mx("stall1", SAOK, 64'h0), wx("stall1", SAOK, IRET, 64'h208, 64'h1234, 4'h4, RNONE));
    setm(SAOK, IOPQ, 64'd30, 64'h0, 4'h2, RNONE);
    W_stall = 1'b1;
    tick(mnone(), wx("stall2", SAOK, IRET, 64'h208, 64'h1234, 4'h4, RNONE));
    setm(SAOK, IOPQ, 64'd30, 64'h0, 4'h2, RNONE);
    tick(mnone(), wx("unstall", SAOK, IOPQ, 64'd30, 64'h0, 4'h2, RNONE));

    // Top-of-memory boundary, and loader bytes past the end dropped.
    setm(SAOK, INOP, 64'h0, 64'h0, RNONE, RNONE);
    load(64'h3F8, 64'hCAFEF00D12345678);
    tick(mnone(), wnone());
    setm(SAOK, IMRMOVQ, 64'h3F8, 64'h0, RNONE, 4'h3);
    tick(mx("top", SAOK, 64'hCAFEF00D12345678),
         wx("top", SAOK, IMRMOVQ, 64'h3F8, 64'hCAFEF00D12345678, RNONE, 4'h3));
    setm(SAOK, INOP, 64'h0, 64'h0, RNONE, RNONE);
    load(64'h3FC, 64'h5566778899AABBCC);
    tick(mnone(), wnone());
    setm(SAOK, IMRMOVQ, 64'h3F8, 64'h0, RNONE, 4'h3);
    tick(mx("ld_clip", SAOK, 64'h99AABBCC12345678),
         wx("ld_clip", SAOK, IMRMOVQ, 64'h3F8, 64'h99AABBCC12345678, RNONE, 4'h3));

    // Faulting store, then W freezes on SADR.
    setm(SAOK, IRMMOVQ, 64'h3FC, 64'hDEAD, RNONE, RNONE);
    tick(mx("st_err", SADR, 64'h0), wx("st_err", SADR, IRMMOVQ, 64'h3FC, 64'h0, RNONE, RNONE));
    setm(SAOK, IMRMOVQ, 64'd1017, 64'h0, RNONE, 4'h3);
    tick(mx("ld_err", SADR, 64'h0), wx("frz1", SADR, IRMMOVQ, 64'h3FC, 64'h0, RNONE, RNONE));
    setm(SAOK, IRMMOVQ, 64'h40, 64'hFFFF, RNONE, RNONE);
    tick(mx("st_frz", SAOK, 64'h0), wx("frz2", SADR, IRMMOVQ, 64'h3FC, 64'h0, RNONE, RNONE));

    // Asynchronous reset mid-cycle with a store still presented on M.
    #3;
    rst_n = 1'b0;
    #1;
    check_w_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    setm(SAOK, IMRMOVQ, 64'h40, 64'h0, RNONE, 4'h1);
    tick(mx("kept40", SAOK, 64'h1122334455667788),
         wx("kept40", SAOK, IMRMOVQ, 64'h40, 64'h1122334455667788, RNONE, 4'h1));
    setm(SAOK, IMRMOVQ, 64'h3F8, 64'h0, RNONE, 4'h3);
    tick(mx("kept3F8", SAOK, 64'h99AABBCC12345678),
         wx("kept3F8", SAOK, IMRMOVQ, 64'h3F8, 64'h99AABBCC12345678, RNONE, 4'h3));
    setm(SAOK, INOP, 64'h0, 64'h0, RNONE, RNONE);
    tick(mnone(), wnone());
    @(negedge clk);

    check64("queues_drained", 64'(mq.size() + wq.size()), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
